ibex_rf_wr_arbiter: RTL

- Shares the single register-file write port between two writeback requesters: req0 (LSU, high priority) and req1 (ALU/EX, low priority).
- Fixed priority, with a starvation counter that guarantees req1 eventually wins.
- The latch-based register file commits a write one cycle after issue. This block therefore holds the issued write for one cycle and forwards it onto both read ports.
- Sits between the writeback stage and the register file, in the ID/WB region of the core.

---
 rtl/ibex_rf_wr_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ibex_rf_wr_arbiter.sv
// ibex_rf_wr_arbiter
//
// Shares the single register-file write port between two writeback requesters.
// req0 (LSU) has fixed high priority. req1 (ALU/EX) is low priority. A starvation
// counter force-grants req1 once it has been refused MaxWait consecutive cycles.
//
// The latch-based register file commits a write one cycle after issue. The
// issued write is therefore held for one cycle and forwarded onto both read ports.
//
// Ports:
//   clk_int, rst_ni                   clock, asynchronous active-low reset
//   req0_valid_i/addr_i/data_i        LSU write request
//   req0_ready_o                      LSU request accepted this cycle
//   req1_valid_i/addr_i/data_i        EX write request
//   req1_ready_o                      EX request accepted this cycle
//   rf_we_o/rf_waddr_o/rf_wdata_o     register-file write port (issued in grant cycle)
//   raddr_a_i, rf_rdata_a_i           read port A address and raw register-file data
//   rdata_a_o                         read port A data after forwarding
//   raddr_b_i, rf_rdata_b_i           read port B address and raw register-file data
//   rdata_b_o                         read port B data after forwarding
//   err_o                             one-cycle pulse after an illegal (RV32E) write is dropped

module ibex_rf_wr_arbiter #(
    parameter int unsigned DataWidth = 32,
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned MaxWait   = 3
) (
    input  logic                 clk_int,
    input  logic                 rst_ni,

    input  logic                 req0_valid_i,
    input  logic [4:0]           req0_addr_i,
    input  logic [DataWidth-1:0] req0_data_i,
    output logic                 req0_ready_o,

    input  logic                 req1_valid_i,
    input  logic [4:0]           req1_addr_i,
    input  logic [DataWidth-1:0] req1_data_i,
    output logic                 req1_ready_o,

    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,

    input  logic [4:0]           raddr_a_i,
    input  logic [DataWidth-1:0] rf_rdata_a_i,
    output logic [DataWidth-1:0] rdata_a_o,

    input  logic [4:0]           raddr_b_i,
    input  logic [DataWidth-1:0] rf_rdata_b_i,
    output logic [DataWidth-1:0] rdata_b_o,

    output logic                 err_o
);

    // The counter saturates at MaxWait, so four bits cover the whole legal range.
    localparam logic [3:0] MaxWaitCnt = 4'(MaxWait);

    if (MaxWait < 1 || MaxWait > 15) begin : gen_bad_max_wait
        $error("MaxWait must be in the range 1..15");
    end

    // Registered state
    logic [3:0]           wait_cnt_q, wait_cnt_d;
    logic                 fwd_valid_q;
    logic [4:0]           fwd_addr_q;
    logic [DataWidth-1:0] fwd_data_q;
    logic                 err_q, err_d;

    // Arbitration and issue
    logic                 boost;
    logic                 grant0, grant1, grant;
    logic [4:0]           sel_addr;
    logic [DataWidth-1:0] sel_data;
    logic                 legal;

    always_comb begin
        boost  = (wait_cnt_q == MaxWaitCnt);
        // In BOOST req1 wins outright; otherwise it only wins when req0 is idle.
        grant1 = req1_valid_i && (boost || !req0_valid_i);
        grant0 = req0_valid_i && !grant1;
        grant  = grant0 || grant1;

        sel_addr = '0;
        sel_data = '0;
        if (grant1) begin
            sel_addr = req1_addr_i;
            sel_data = req1_data_i;
        end else if (grant0) begin
            sel_addr = req0_addr_i;
            sel_data = req0_data_i;
        end

        legal = !(RV32E && sel_addr[4]);

        // x0 writes and illegal targets are acknowledged but never reach the register file.
        req0_ready_o = grant0;
        req1_ready_o = grant1;
        rf_we_o      = grant && (sel_addr != 5'd0) && legal;
        rf_waddr_o   = sel_addr;
        rf_wdata_o   = sel_data;

        err_d = grant && !legal;

        // Count consecutive refusals of a pending req1, saturating at MaxWait.
        if (!req1_valid_i || grant1) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q >= MaxWaitCnt) begin
            wait_cnt_d = MaxWaitCnt;
        end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q  <= 4'd0;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= 5'd0;
            fwd_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            fwd_valid_q <= rf_we_o;
            err_q       <= err_d;
            if (rf_we_o) begin
                fwd_addr_q <= rf_waddr_o;
                fwd_data_q <= rf_wdata_o;
            end
        end
    end

    assign err_o = err_q;

    // Forward the write issued last cycle; it is not yet visible in the latch array.
    // fwd_addr_q is never x0 while valid, so x0 reads always pass through.
    assign rdata_a_o = (fwd_valid_q && (raddr_a_i == fwd_addr_q)) ? fwd_data_q : rf_rdata_a_i;
    assign rdata_b_o = (fwd_valid_q && (raddr_b_i == fwd_addr_q)) ? fwd_data_q : rf_rdata_b_i;

endmodule
